// File: rtl/maze_run_ctrl.sv
// Run sequencer for the maze path search: owns the map port, starts the solver, replays the solved path.
// Optional SEARCH_TIMEOUT_EN bounds the SEARCH phase to TIMEOUT_CYCLES cycles.
module maze_run_ctrl #(
  parameter int ADDR_WIDTH     = 8,
  parameter int STK_AW         = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  host_start,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic                  host_din,
  output logic                  solver_start,
  input  logic                  solver_done,
  input  logic                  solver_fail,
  input  logic                  solver_we,
  input  logic [ADDR_WIDTH-1:0] solver_addr,
  input  logic                  solver_din,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_din,
  input  logic [STK_AW:0]       stk_depth,
  output logic [STK_AW-1:0]     stk_rd_addr,
  input  logic [1:0]            stk_rd_data,
  output logic                  move_valid,
  output logic [1:0]            move_dir,
  input  logic                  move_ready,
  output logic [STK_AW:0]       path_len,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic                  timeout
);

  typedef enum logic [2:0] {IDLE, SEARCH, RD, PRESENT, DONE, FAIL} state_t;

  state_t            state_reg, state_next;
  logic [STK_AW-1:0] idx_reg, idx_next;
  logic [STK_AW:0]   path_len_reg, path_len_next;
  logic [1:0]        dir_reg, dir_next;
  logic              timeout_reg, timeout_next;
  logic              busy_reg, done_reg, fail_reg, valid_reg;
  logic              host_owns;
  logic              tmo_hit;

`ifdef SEARCH_TIMEOUT_EN
  logic [15:0] tcnt_reg, tcnt_next;

  // Counter holds the number of SEARCH cycles already completed.
  assign tmo_hit = (tcnt_reg == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tcnt_reg <= '0;
    else      tcnt_reg <= tcnt_next;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  assign host_owns = (state_reg == IDLE) || (state_reg == DONE) || (state_reg == FAIL);

  always_comb begin
    if (host_owns) begin
      mem_we   = host_we;
      mem_addr = host_addr;
      mem_din  = host_din;
    end else begin
      mem_we   = solver_we;
      mem_addr = solver_addr;
      mem_din  = solver_din;
    end
  end

  always_comb begin
    state_next    = state_reg;
    idx_next      = idx_reg;
    path_len_next = path_len_reg;
    dir_next      = dir_reg;
    timeout_next  = timeout_reg;
`ifdef SEARCH_TIMEOUT_EN
    tcnt_next     = tcnt_reg;
`endif
    case (state_reg)
      IDLE, DONE, FAIL: begin
        if (host_start) begin
          state_next   = SEARCH;
          timeout_next = 1'b0;
`ifdef SEARCH_TIMEOUT_EN
          tcnt_next    = '0;
`endif
        end
      end
      SEARCH: begin
`ifdef SEARCH_TIMEOUT_EN
        tcnt_next = tcnt_reg + 16'd1;
`endif
        if (solver_fail) begin
          state_next = FAIL;
        end else if (solver_done) begin
          path_len_next = stk_depth;
          if (stk_depth == '0) begin
            state_next = DONE;
          end else begin
            idx_next   = '0;
            state_next = RD;
          end
        end else if (tmo_hit) begin
          state_next   = FAIL;
          timeout_next = 1'b1;
        end
      end
      RD: begin
        dir_next   = stk_rd_data;
        state_next = PRESENT;
      end
      PRESENT: begin
        if (move_ready) begin
          if ({1'b0, idx_reg} == path_len_reg - 1'b1) begin
            state_next = DONE;
          end else begin
            idx_next   = idx_reg + 1'b1;
            state_next = RD;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Status flags are registered from the next state so they line up with state_reg.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      idx_reg      <= '0;
      path_len_reg <= '0;
      dir_reg      <= '0;
      timeout_reg  <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      fail_reg     <= 1'b0;
      valid_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      idx_reg      <= idx_next;
      path_len_reg <= path_len_next;
      dir_reg      <= dir_next;
      timeout_reg  <= timeout_next;
      busy_reg     <= (state_next == SEARCH) || (state_next == RD) || (state_next == PRESENT);
      done_reg     <= (state_next == DONE);
      fail_reg     <= (state_next == FAIL);
      valid_reg    <= (state_next == PRESENT);
    end
  end

  assign solver_start = (state_reg == SEARCH);
  assign stk_rd_addr  = idx_reg;
  assign move_valid   = valid_reg;
  assign move_dir     = dir_reg;
  assign path_len     = path_len_reg;
  assign busy         = busy_reg;
  assign done         = done_reg;
  assign fail         = fail_reg;
  assign timeout      = timeout_reg;

endmodule
